// File: rtl/sdft_scheduler.sv
// Sample-rate divider, per-bin issue sequencer and double-buffered magnitude
// store that sits between the ADC, the sliding-DFT core and the VGA bar renderer.
module sdft_scheduler #(
  parameter int data_width = 8,
  parameter int freq_bins  = 16,
  parameter int mag_width  = 23,
  parameter int sample_div = 1024,
  parameter int bin_w      = $clog2(freq_bins)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [data_width-1:0] adc,
  input  logic                  vsync,
  output logic                  adc_clk,
  output logic [data_width-1:0] core_sample,
  output logic [bin_w-1:0]      core_bin,
  output logic                  core_valid,
  input  logic                  core_ready,
  input  logic                  res_valid,
  input  logic [bin_w-1:0]      res_bin,
  input  logic [mag_width-1:0]  res_mag,
  input  logic [bin_w-1:0]      disp_bin,
  output logic [mag_width-1:0]  disp_mag,
  output logic                  busy,
  output logic                  overrun
);

  localparam int div_w = $clog2(sample_div);
  localparam int cnt_w = bin_w + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [div_w-1:0]     div_cnt;
  logic [cnt_w-1:0]     res_cnt;
  logic                 tick;
  logic                 xfer;
  logic                 last_bin;
  logic                 res_full;
  logic                 sweep_start;
  logic                 sweep_done;
  logic                 swap;
  logic                 front_sel;
  logic                 front_valid;
  logic                 back_full;
  logic                 vsync_q;
  logic [mag_width-1:0] bank [2*freq_bins];

  assign tick     = (div_cnt == div_w'(sample_div - 1));
  assign adc_clk  = (div_cnt < div_w'(sample_div / 2));
  assign last_bin = (core_bin == bin_w'(freq_bins - 1));
  assign res_full = (res_cnt == cnt_w'(freq_bins));
  assign xfer     = core_valid && core_ready;
  assign swap     = vsync && !vsync_q && back_full;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    core_valid  = 1'b0;
    sweep_start = 1'b0;
    sweep_done  = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt   = ISSUE;
          sweep_start = 1'b1;
        end
      end
      ISSUE: begin
        core_valid = 1'b1;
        if (core_ready && last_bin) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (res_full) begin
          state_nxt  = IDLE;
          sweep_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      core_sample <= '0;
      core_bin    <= '0;
      res_cnt     <= '0;
      back_full   <= 1'b0;
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      vsync_q     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state   <= state_nxt;
      vsync_q <= vsync;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      // A tick outside IDLE is a lost sample; state is deliberately left alone
      if (tick && state != IDLE) overrun <= 1'b1;
      if (sweep_start) begin
        core_sample <= adc;
        core_bin    <= '0;
      end else if (xfer && !last_bin) begin
        core_bin <= core_bin + 1'b1;
      end
      if (sweep_start) res_cnt <= '0;
      else if (res_valid && !res_full) res_cnt <= res_cnt + 1'b1;
      if (swap) begin
        front_sel   <= ~front_sel;
        front_valid <= 1'b1;
      end
      // Newest spectrum wins: a fresh sweep invalidates an unswapped back bank
      if (sweep_start || swap) back_full <= 1'b0;
      else if (sweep_done) back_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res_valid) bank[{~front_sel, res_bin}] <= res_mag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) disp_mag <= '0;
    else disp_mag <= front_valid ? bank[{front_sel, disp_bin}] : '0;
  end

endmodule

// File: tb/tb_sdft_scheduler.sv
// Directed bench for sdft_scheduler with freq_bins=4, sample_div=16 and a
// core model that echoes bin+mag_base two cycles after each issue.
module tb_sdft_scheduler;

  logic        clk;
  logic        reset_n;
  logic [7:0]  adc;
  logic        vsync;
  logic        adc_clk;
  logic [7:0]  core_sample;
  logic [1:0]  core_bin;
  logic        core_valid;
  logic        core_ready;
  logic        res_valid;
  logic [1:0]  res_bin;
  logic [22:0] res_mag;
  logic [1:0]  disp_bin;
  logic [22:0] disp_mag;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int mag_base = 10;
  logic echo_en = 1'b1;
  logic s1_v, s2_v;
  logic [1:0] s1_b, s2_b;

  sdft_scheduler #(
    .data_width(8), .freq_bins(4), .mag_width(23), .sample_div(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .adc(adc), .vsync(vsync), .adc_clk(adc_clk),
    .core_sample(core_sample), .core_bin(core_bin), .core_valid(core_valid),
    .core_ready(core_ready), .res_valid(res_valid), .res_bin(res_bin),
    .res_mag(res_mag), .disp_bin(disp_bin), .disp_mag(disp_mag),
    .busy(busy), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core model: samples after the bench has driven core_ready for this cycle
  initial begin
    res_valid = 1'b0; res_bin = '0; res_mag = '0;
    s1_v = 1'b0; s2_v = 1'b0; s1_b = '0; s2_b = '0;
    forever begin
      @(negedge clk); #2;
      if (!reset_n) begin
        res_valid = 1'b0; s1_v = 1'b0; s2_v = 1'b0;
      end else begin
        res_valid = s2_v && echo_en;
        res_bin   = s2_b;
        res_mag   = 23'(mag_base + int'(s2_b));
        s2_v = s1_v; s2_b = s1_b;
        s1_v = core_valid && core_ready;
        s1_b = core_bin;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(negedge clk); #1;
    cyc++;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset;
    reset_n = 1'b0; vsync = 1'b0; core_ready = 1'b1; echo_en = 1'b1;
    disp_bin = '0; mag_base = 10;
    step(); step();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset;
    logic exp_clk, exp_valid;
    reset_n = 1'b0; adc = 8'h5A; vsync = 1'b0; core_ready = 1'b1; disp_bin = '0;
    step(); step();
    checks++;
    if ({adc_clk, core_valid, busy, overrun, core_bin, core_sample, disp_mag} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 23'd0})
      $display("FAIL reset_values: got %h expected %h",
               {adc_clk, core_valid, busy, overrun, core_bin, core_sample, disp_mag},
               {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 23'd0});
    else passed++;
    reset_n = 1'b1; cyc = 0;
    for (int c = 0; c < 32; c++) begin
      exp_clk   = ((c % 16) < 8);
      exp_valid = (c >= 16 && c <= 19);
      checks++;
      if (adc_clk !== exp_clk) $display("FAIL adc_clk_c%0d: got %b expected %b", c, adc_clk, exp_clk);
      else passed++;
      checks++;
      if (core_valid !== exp_valid) $display("FAIL first_tick_c%0d: got %b expected %b", c, core_valid, exp_valid);
      else passed++;
      step();
    end
  endtask

  task automatic test_sweep_swap;
    do_reset(); adc = 8'hA5;
    wait_cyc(15);
    checks++;
    if (busy !== 1'b0) $display("FAIL idle_at_tick: got %b expected 0", busy); else passed++;
    for (int b = 0; b < 4; b++) begin
      wait_cyc(16 + b);
      checks++;
      if ({core_valid, core_bin, core_sample} !== {1'b1, 2'(b), 8'hA5})
        $display("FAIL issue_bin%0d: got %h expected %h", b, {core_valid, core_bin, core_sample}, {1'b1, 2'(b), 8'hA5});
      else passed++;
    end
    wait_cyc(20);
    checks++;
    if ({core_valid, busy} !== 2'b01) $display("FAIL drain_entry: got %b expected 01", {core_valid, busy}); else passed++;
    wait_cyc(22);
    checks++;
    if (busy !== 1'b1) $display("FAIL drain_hold: got %b expected 1", busy); else passed++;
    wait_cyc(23);
    checks++;
    if (busy !== 1'b0) $display("FAIL busy_fall: got %b expected 0", busy); else passed++;
    checks++;
    if (disp_mag !== 23'd0) $display("FAIL pre_swap_disp: got %0d expected 0", disp_mag); else passed++;
    vsync = 1'b1; step(); vsync = 1'b0;
    checks++;
    if (disp_mag !== 23'd0) $display("FAIL swap_latency: got %0d expected 0", disp_mag); else passed++;
    step();
    checks++;
    if (disp_mag !== 23'd10) $display("FAIL disp_bin0: got %0d expected 10", disp_mag); else passed++;
    for (int b = 1; b < 4; b++) begin
      disp_bin = 2'(b); step();
      checks++;
      if (disp_mag !== 23'(10 + b)) $display("FAIL disp_bin%0d: got %0d expected %0d", b, disp_mag, 10 + b);
      else passed++;
    end
  endtask

  task automatic test_stall_overrun;
    do_reset(); adc = 8'h3C;
    wait_cyc(18); core_ready = 1'b0;
    checks++;
    if (core_bin !== 2'd2) $display("FAIL stall_start_bin: got %0d expected 2", core_bin); else passed++;
    wait_cyc(20); adc = 8'hFF;
    wait_cyc(30);
    checks++;
    if (overrun !== 1'b0) $display("FAIL overrun_early: got %b expected 0", overrun); else passed++;
    wait_cyc(32);
    checks++;
    if ({core_valid, core_bin, core_sample} !== {1'b1, 2'd2, 8'h3C})
      $display("FAIL stall_hold: got %h expected %h", {core_valid, core_bin, core_sample}, {1'b1, 2'd2, 8'h3C});
    else passed++;
    checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun); else passed++;
    wait_cyc(37);
    checks++;
    if ({core_valid, core_bin, core_sample} !== {1'b1, 2'd2, 8'h3C})
      $display("FAIL stall_end: got %h expected %h", {core_valid, core_bin, core_sample}, {1'b1, 2'd2, 8'h3C});
    else passed++;
    wait_cyc(38); core_ready = 1'b1;
    wait_cyc(39);
    checks++;
    if (core_bin !== 2'd3) $display("FAIL resume_bin: got %0d expected 3", core_bin); else passed++;
    wait_cyc(40);
    checks++;
    if ({core_valid, busy} !== 2'b01) $display("FAIL resume_drain: got %b expected 01", {core_valid, busy}); else passed++;
    wait_cyc(43);
    checks++;
    if (busy !== 1'b0) $display("FAIL resume_done: got %b expected 0", busy); else passed++;
    wait_cyc(46);
    checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", overrun); else passed++;
  endtask

  task automatic test_two_sweeps;
    do_reset(); adc = 8'h11;
    wait_cyc(23);
    checks++;
    if (busy !== 1'b0) $display("FAIL sweep1_done: got %b expected 0", busy); else passed++;
    mag_base = 20;
    wait_cyc(32);
    checks++;
    if (core_valid !== 1'b1) $display("FAIL sweep2_start: got %b expected 1", core_valid); else passed++;
    wait_cyc(39);
    vsync = 1'b1; step(); vsync = 1'b0; step();
    checks++;
    if (disp_mag !== 23'd20) $display("FAIL newest_bin0: got %0d expected 20", disp_mag); else passed++;
    for (int b = 1; b < 4; b++) begin
      disp_bin = 2'(b); step();
      checks++;
      if (disp_mag !== 23'(20 + b)) $display("FAIL newest_bin%0d: got %0d expected %0d", b, disp_mag, 20 + b);
      else passed++;
    end
    echo_en = 1'b0;
    wait_cyc(56); disp_bin = 2'd0;
    vsync = 1'b1; step(); vsync = 1'b0; step();
    for (int b = 0; b < 4; b++) begin
      disp_bin = 2'(b); step();
      checks++;
      if (disp_mag !== 23'(20 + b)) $display("FAIL no_reswap_bin%0d: got %0d expected %0d", b, disp_mag, 20 + b);
      else passed++;
    end
  endtask

  task automatic test_vsync_drain;
    do_reset(); adc = 8'h22; disp_bin = 2'd1;
    wait_cyc(21);
    vsync = 1'b1; step(); vsync = 1'b0;
    wait_cyc(23);
    checks++;
    if (disp_mag !== 23'd0) $display("FAIL partial_no_swap: got %0d expected 0", disp_mag); else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL partial_done: got %b expected 0", busy); else passed++;
    wait_cyc(24);
    checks++;
    if (disp_mag !== 23'd0) $display("FAIL partial_still_old: got %0d expected 0", disp_mag); else passed++;
    vsync = 1'b1; step(); vsync = 1'b0; step();
    checks++;
    if (disp_mag !== 23'd11) $display("FAIL late_swap: got %0d expected 11", disp_mag); else passed++;
  endtask

  task automatic test_reset_mid;
    logic exp_clk, exp_valid;
    do_reset(); adc = 8'h77;
    wait_cyc(17);
    checks++;
    if ({core_valid, core_bin} !== {1'b1, 2'd1}) $display("FAIL mid_issue_pre: got %b expected 101", {core_valid, core_bin});
    else passed++;
    reset_n = 1'b0; #1;
    checks++;
    if ({adc_clk, core_valid, busy, overrun, core_bin, core_sample, disp_mag} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 23'd0})
      $display("FAIL mid_reset_values: got %h expected %h",
               {adc_clk, core_valid, busy, overrun, core_bin, core_sample, disp_mag},
               {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 23'd0});
    else passed++;
    step();
    reset_n = 1'b1; cyc = 0;
    for (int c = 0; c < 32; c++) begin
      exp_clk   = ((c % 16) < 8);
      exp_valid = (c >= 16 && c <= 19);
      checks++;
      if (adc_clk !== exp_clk) $display("FAIL rel_adc_clk_c%0d: got %b expected %b", c, adc_clk, exp_clk);
      else passed++;
      checks++;
      if (core_valid !== exp_valid) $display("FAIL rel_tick_c%0d: got %b expected %b", c, core_valid, exp_valid);
      else passed++;
      step();
    end
  endtask

  initial begin
    reset_n = 1'b0; adc = '0; vsync = 1'b0; core_ready = 1'b1; disp_bin = '0;
    test_reset();
    test_sweep_swap();
    test_stall_overrun();
    test_two_sweeps();
    test_vsync_drain();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
